// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-requester arbiter in front of the single-port sdram controller
// Latches one request per port, issues one controller command at a time, routes completion back.
module sdram_port_arbiter #(
   parameter int ADDR_WIDTH = 21,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4,
   parameter int ARB_MODE   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_data,
   input  logic [BE_WIDTH-1:0]   p0_byte_en,
   input  logic                  p0_wr,
   input  logic                  p0_rd,
   output logic                  p0_busy,
   output logic                  p0_ready,
   output logic [DATA_WIDTH-1:0] p0_q,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_data,
   input  logic [BE_WIDTH-1:0]   p1_byte_en,
   input  logic                  p1_wr,
   input  logic                  p1_rd,
   output logic                  p1_busy,
   output logic                  p1_ready,
   output logic [DATA_WIDTH-1:0] p1_q,
   output logic [ADDR_WIDTH-1:0] ctrl_addr,
   output logic [DATA_WIDTH-1:0] ctrl_data,
   output logic [BE_WIDTH-1:0]   ctrl_byte_en,
   output logic                  ctrl_wr,
   output logic                  ctrl_rd,
   input  logic [DATA_WIDTH-1:0] ctrl_q,
   input  logic                  ctrl_available,
   input  logic                  ctrl_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] p0_addr_r, p1_addr_r;
   logic [DATA_WIDTH-1:0] p0_data_r, p1_data_r;
   logic [BE_WIDTH-1:0]   p0_be_r, p1_be_r;
   logic                  p0_op_wr, p1_op_wr;
   logic                  grant;
   logic                  grant_op_wr;
   logic                  last_grant;
   logic                  pick;
   logic                  pick_wr;

   // pick is only meaningful while at least one port is pending
   always_comb begin
      pick = 1'b0;
      if (ARB_MODE == 1)
         pick = !p0_busy;
      else if (p0_busy && p1_busy)
         pick = !last_grant;
      else
         pick = !p0_busy;
      pick_wr = pick ? p1_op_wr : p0_op_wr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         p0_busy      <= 1'b0;
         p1_busy      <= 1'b0;
         p0_ready     <= 1'b0;
         p1_ready     <= 1'b0;
         p0_q         <= '0;
         p1_q         <= '0;
         p0_addr_r    <= '0;
         p1_addr_r    <= '0;
         p0_data_r    <= '0;
         p1_data_r    <= '0;
         p0_be_r      <= '0;
         p1_be_r      <= '0;
         p0_op_wr     <= 1'b0;
         p1_op_wr     <= 1'b0;
         grant        <= 1'b0;
         grant_op_wr  <= 1'b0;
         last_grant   <= 1'b1;
         ctrl_addr    <= '0;
         ctrl_data    <= '0;
         ctrl_byte_en <= '0;
         ctrl_wr      <= 1'b0;
         ctrl_rd      <= 1'b0;
      end else begin
         p0_ready <= 1'b0;
         p1_ready <= 1'b0;

         // capture never collides with completion: completion only clears a busy port
         if (!p0_busy && (p0_wr || p0_rd)) begin
            p0_busy   <= 1'b1;
            p0_addr_r <= p0_addr;
            p0_data_r <= p0_data;
            p0_be_r   <= p0_byte_en;
            p0_op_wr  <= p0_wr;
         end
         if (!p1_busy && (p1_wr || p1_rd)) begin
            p1_busy   <= 1'b1;
            p1_addr_r <= p1_addr;
            p1_data_r <= p1_data;
            p1_be_r   <= p1_byte_en;
            p1_op_wr  <= p1_wr;
         end

         case (state)
            IDLE: begin
               if ((p0_busy || p1_busy) && ctrl_available) begin
                  grant        <= pick;
                  grant_op_wr  <= pick_wr;
                  ctrl_addr    <= pick ? p1_addr_r : p0_addr_r;
                  ctrl_data    <= pick ? p1_data_r : p0_data_r;
                  ctrl_byte_en <= pick ? p1_be_r : p0_be_r;
                  ctrl_wr      <= pick_wr;
                  ctrl_rd      <= !pick_wr;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               ctrl_wr <= 1'b0;
               ctrl_rd <= 1'b0;
               state   <= WAIT;
            end
            WAIT: begin
               if (ctrl_ready) begin
                  if (grant) begin
                     p1_ready <= 1'b1;
                     p1_busy  <= 1'b0;
                     if (!grant_op_wr)
                        p1_q <= ctrl_q;
                  end else begin
                     p0_ready <= 1'b1;
                     p0_busy  <= 1'b0;
                     if (!grant_op_wr)
                        p0_q <= ctrl_q;
                  end
                  last_grant <= grant;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
   localparam int AW = 21;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int LAT = 3;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } cmd_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_data, p1_data;
   logic [BW-1:0] p0_byte_en, p1_byte_en;
   logic          p0_wr, p0_rd, p1_wr, p1_rd;
   logic          p0_busy, p1_busy, p0_ready, p1_ready;
   logic [DW-1:0] p0_q, p1_q;
   logic [AW-1:0] c0_addr;
   logic [DW-1:0] c0_data;
   logic [BW-1:0] c0_be;
   logic          c0_wr, c0_rd, c0_avail, c0_ready;
   logic [DW-1:0] c0_q;
   logic          mdl_rdy, force_rdy, mute;
   logic [DW-1:0] mdl_q;

   logic          f_busy0, f_busy1, f_ready0, f_ready1;
   logic [DW-1:0] f_q0, f_q1;
   logic [AW-1:0] f_addr;
   logic [DW-1:0] f_data;
   logic [BW-1:0] f_be;
   logic          f_wr, f_rd, f_ready_in, f_avail;
   logic [DW-1:0] f_q_in;

   assign c0_ready = mdl_rdy | force_rdy;
   assign c0_q     = force_rdy ? 32'hffff_ffff : mdl_q;

   sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ARB_MODE(0)) dut (
      .clk(clk), .reset(reset),
      .p0_addr(p0_addr), .p0_data(p0_data), .p0_byte_en(p0_byte_en), .p0_wr(p0_wr), .p0_rd(p0_rd),
      .p0_busy(p0_busy), .p0_ready(p0_ready), .p0_q(p0_q),
      .p1_addr(p1_addr), .p1_data(p1_data), .p1_byte_en(p1_byte_en), .p1_wr(p1_wr), .p1_rd(p1_rd),
      .p1_busy(p1_busy), .p1_ready(p1_ready), .p1_q(p1_q),
      .ctrl_addr(c0_addr), .ctrl_data(c0_data), .ctrl_byte_en(c0_be), .ctrl_wr(c0_wr), .ctrl_rd(c0_rd),
      .ctrl_q(c0_q), .ctrl_available(c0_avail), .ctrl_ready(c0_ready)
   );

   sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ARB_MODE(1)) dut_fp (
      .clk(clk), .reset(reset),
      .p0_addr(p0_addr), .p0_data(p0_data), .p0_byte_en(p0_byte_en), .p0_wr(p0_wr), .p0_rd(p0_rd),
      .p0_busy(f_busy0), .p0_ready(f_ready0), .p0_q(f_q0),
      .p1_addr(p1_addr), .p1_data(p1_data), .p1_byte_en(p1_byte_en), .p1_wr(p1_wr), .p1_rd(p1_rd),
      .p1_busy(f_busy1), .p1_ready(f_ready1), .p1_q(f_q1),
      .ctrl_addr(f_addr), .ctrl_data(f_data), .ctrl_byte_en(f_be), .ctrl_wr(f_wr), .ctrl_rd(f_rd),
      .ctrl_q(f_q_in), .ctrl_available(f_avail), .ctrl_ready(f_ready_in)
   );

   int            n_checks = 0;
   int            n_pass = 0;
   int            ncmd = 0;
   int            lg_m;
   cmd_t          exp_cmd[$];
   logic [DW-1:0] exp_q0[$], exp_q1[$];
   logic [AW-1:0] fp_addrs[$];
   logic [DW-1:0] rmem[logic [AW-1:0]];
   logic [DW-1:0] smem[logic [AW-1:0]];
   logic [DW-1:0] mq0, mq1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return {11'h7a5, a};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_op(input int port, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be, input bit want_ready);
      cmd_t c;
      c.wr = wr; c.addr = a; c.data = d; c.be = be;
      exp_cmd.push_back(c);
      if (wr) rmem[a] = d;
      else if (port == 0) mq0 = rmem.exists(a) ? rmem[a] : dflt(a);
      else mq1 = rmem.exists(a) ? rmem[a] : dflt(a);
      if (want_ready) begin
         if (port == 0) exp_q0.push_back(mq0);
         else exp_q1.push_back(mq1);
      end
      lg_m = port;
   endtask

   task automatic drive(input int port, input logic wr, input logic rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
      if (port == 0) begin
         p0_wr = wr; p0_rd = rd; p0_addr = a; p0_data = d; p0_byte_en = be;
      end else begin
         p1_wr = wr; p1_rd = rd; p1_addr = a; p1_data = d; p1_byte_en = be;
      end
   endtask

   task automatic release_all();
      p0_wr = 1'b0; p0_rd = 1'b0; p1_wr = 1'b0; p1_rd = 1'b0;
   endtask

   task automatic op(input int port, input logic wr, input logic rd, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [BW-1:0] be);
      push_op(port, wr, a, d, be, 1'b1);
      drive(port, wr, rd, a, d, be);
      tick();
      release_all();
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (t < 400 && (p0_busy || p1_busy || f_busy0 || f_busy1 || exp_cmd.size() != 0 ||
                         exp_q0.size() != 0 || exp_q1.size() != 0)) begin
         tick();
         t++;
      end
      check("wait_idle_timeout", 64'(t >= 400), 0);
      tick();
      tick();
   endtask

   task automatic pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input bit do_wait);
      if (lg_m == 1) begin
         push_op(0, 1'b0, a0, 0, 4'hf, 1'b1);
         push_op(1, 1'b0, a1, 0, 4'hf, 1'b1);
      end else begin
         push_op(1, 1'b0, a1, 0, 4'hf, 1'b1);
         push_op(0, 1'b0, a0, 0, 4'hf, 1'b1);
      end
      fp_addrs.delete();
      drive(0, 1'b0, 1'b1, a0, 0, 4'hf);
      drive(1, 1'b0, 1'b1, a1, 0, 4'hf);
      tick();
      release_all();
      if (do_wait) begin
         wait_idle();
         check("fp_two_cmds", 64'(fp_addrs.size()), 2);
         if (fp_addrs.size() > 0) check("fp_p0_first", fp_addrs[0], a0);
      end
   endtask

   // controller stand-in for the round-robin instance
   initial begin
      cmd_t          e;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          w;
      mdl_rdy = 1'b0;
      mdl_q = '0;
      forever begin
         @(negedge clk);
         if (!reset && (c0_wr || c0_rd)) begin
            ncmd++;
            a = c0_addr; d = c0_data; w = c0_wr;
            if (exp_cmd.size() == 0) begin
               check("ctrl_cmd_spurious", {c0_wr, c0_rd}, 2'b00);
            end else begin
               e = exp_cmd.pop_front();
               check("ctrl_cmd_op", {c0_wr, c0_rd}, {e.wr, !e.wr});
               check("ctrl_cmd_addr", c0_addr, e.addr);
               check("ctrl_cmd_be", c0_be, e.be);
               if (e.wr) check("ctrl_cmd_data", c0_data, e.data);
            end
            @(negedge clk);
            check("ctrl_cmd_one_cycle", {c0_wr, c0_rd}, 2'b00);
            repeat (LAT) @(negedge clk);
            if (!mute) begin
               check("ctrl_addr_stable", c0_addr, a);
               if (w) begin
                  smem[a] = d;
                  mdl_q = 32'hbad0_bad0;
               end else begin
                  mdl_q = smem.exists(a) ? smem[a] : dflt(a);
               end
               mdl_rdy = 1'b1;
               @(negedge clk);
               mdl_rdy = 1'b0;
               mdl_q = '0;
            end
         end
      end
   end

   // controller stand-in for the fixed-priority instance: records issue order only
   initial begin
      f_ready_in = 1'b0;
      f_q_in = '0;
      f_avail = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset && (f_wr || f_rd)) begin
            fp_addrs.push_back(f_addr);
            repeat (2) @(negedge clk);
            f_ready_in = 1'b1;
            @(negedge clk);
            f_ready_in = 1'b0;
         end
      end
   end

   // completion monitor: ready pulses pop the per-port scoreboards
   initial begin
      logic pb0, pb1, pr;
      pb0 = 1'b0; pb1 = 1'b0; pr = 1'b1;
      forever begin
         @(negedge clk);
         if (p0_ready) begin
            if (exp_q0.size() == 0) check("p0_ready_spurious", p0_ready, 0);
            else check("p0_q", p0_q, exp_q0.pop_front());
         end
         if (p1_ready) begin
            if (exp_q1.size() == 0) check("p1_ready_spurious", p1_ready, 0);
            else check("p1_q", p1_q, exp_q1.pop_front());
         end
         if (!reset && !pr) begin
            if (pb0 && !p0_busy) check("p0_busy_until_ready", p0_ready, 1);
            if (pb1 && !p1_busy) check("p1_busy_until_ready", p1_ready, 1);
         end
         pb0 = p0_busy; pb1 = p1_busy; pr = reset;
      end
   end

   initial begin
      int n;
      int t;
      reset = 1'b1; c0_avail = 1'b1; mute = 1'b0; force_rdy = 1'b0;
      release_all();
      p0_addr = '0; p0_data = '0; p0_byte_en = '0;
      p1_addr = '0; p1_data = '0; p1_byte_en = '0;
      mq0 = '0; mq1 = '0; lg_m = 1;
      repeat (3) tick();
      check("rst_port_flags", {p0_busy, p1_busy, p0_ready, p1_ready}, 0);
      check("rst_ctrl_cmd", {c0_wr, c0_rd}, 0);
      check("rst_port_q", {p0_q, p1_q}, 0);
      check("rst_ctrl_fields", {c0_addr, c0_data, c0_be}, 0);
      reset = 1'b0;
      tick();

      // single write from port 0, minimum latency
      push_op(0, 1'b1, 21'h002020, 32'h1234, 4'hf, 1'b1);
      drive(0, 1'b1, 1'b0, 21'h002020, 32'h1234, 4'hf);
      tick();
      release_all();
      check("t1_p0_busy", p0_busy, 1);
      check("t1_p1_busy", p1_busy, 0);
      check("t1_no_cmd_yet", c0_wr, 0);
      tick();
      check("t1_cmd_latency", c0_wr, 1);
      wait_idle();
      check("t1_p1_q", p1_q, 0);

      // write by port 0, read back by port 1
      op(0, 1'b1, 1'b0, 21'h002021, 32'h5678, 4'hf);
      wait_idle();
      op(1, 1'b0, 1'b1, 21'h002021, 0, 4'hf);
      wait_idle();
      check("t2_p1_q", p1_q, 32'h5678);
      check("t2_p0_q", p0_q, 0);

      // simultaneous reads; a lone p0 read before round 2 flips who goes first
      for (int r = 0; r < 4; r++) begin
         if (r == 2) begin
            op(0, 1'b0, 1'b1, 21'h002020, 0, 4'hf);
            wait_idle();
         end
         pair(21'h000100 + 21'(r), 21'h000200 + 21'(r), 1'b1);
      end

      // controller unavailable with both pending
      c0_avail = 1'b0;
      n = ncmd;
      pair(21'h000300, 21'h000301, 1'b0);
      repeat (20) tick();
      check("t4_no_cmd_count", 64'(ncmd - n), 0);
      check("t4_no_cmd_lines", {c0_wr, c0_rd}, 0);
      c0_avail = 1'b1;
      tick();
      check("t4_issue_first_avail", c0_rd, 1);
      wait_idle();

      // wr and rd together, then a request while busy
      n = ncmd;
      push_op(0, 1'b1, 21'h002030, 32'hcafe_f00d, 4'h3, 1'b1);
      drive(0, 1'b1, 1'b1, 21'h002030, 32'hcafe_f00d, 4'h3);
      tick();
      drive(0, 1'b0, 1'b1, 21'h002031, 0, 4'hf);
      tick();
      release_all();
      wait_idle();
      check("t5_single_cmd", 64'(ncmd - n), 1);
      op(1, 1'b0, 1'b1, 21'h002030, 0, 4'hf);
      wait_idle();

      // reset while waiting on the controller
      mute = 1'b1;
      push_op(1, 1'b0, 21'h002040, 0, 4'hf, 1'b0);
      drive(1, 1'b0, 1'b1, 21'h002040, 0, 4'hf);
      tick();
      release_all();
      repeat (6) tick();
      check("t6_wait_busy", p1_busy, 1);
      reset = 1'b1;
      tick();
      check("t6_port_flags", {p0_busy, p1_busy, p0_ready, p1_ready}, 0);
      check("t6_ctrl_cmd", {c0_wr, c0_rd}, 0);
      check("t6_ctrl_fields", {c0_addr, c0_data, c0_be}, 0);
      check("t6_port_q", {p0_q, p1_q}, 0);
      reset = 1'b0;
      mute = 1'b0;
      mq0 = '0; mq1 = '0; lg_m = 1;
      tick();
      force_rdy = 1'b1;
      tick();
      force_rdy = 1'b0;
      repeat (3) tick();
      check("t6_late_ready_q", p1_q, 0);
      check("t6_late_ready_busy", {p0_busy, p1_busy}, 0);

      // resubmit the cycle after the ready pulse
      op(0, 1'b0, 1'b1, 21'h002021, 0, 4'hf);
      t = 0;
      while (!p0_ready && t < 100) begin
         tick();
         t++;
      end
      check("t7_ready_seen", 64'(t < 100), 1);
      push_op(0, 1'b0, 21'h002020, 0, 4'hf, 1'b1);
      drive(0, 1'b0, 1'b1, 21'h002020, 0, 4'hf);
      tick();
      release_all();
      check("t7_resubmit_busy", p0_busy, 1);
      wait_idle();
      check("t7_p0_q", p0_q, 32'h1234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
